// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
// Bundles every non-clock/reset signal of the ALU sequencer into one interface.
//
// Signal groups:
//   instr_*      : instruction handshake (valid/ready, opcode, rd, rs1, rs2)
//   ld_*         : register preload handshake (valid/ready, addr, data)
//   alu_*        : operands/opcode to the external ALU and its combinational result
//   done         : one-cycle retire pulse
//   dbg_*        : combinational register-file read port
//   instr_count  : 16-bit count of retired instructions
//
// Modports:
//   slave  : the sequencer side
//   master : the side that issues instructions, preloads and models the ALU
interface alu_sequencer_if #(
    parameter int IN_WIDTH     = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int NUM_REGS     = 8
);
    localparam int RW = $clog2(NUM_REGS);

    logic                    instr_valid;
    logic                    instr_ready;
    logic [OPCODE_WIDTH-1:0] instr_opcode;
    logic [RW-1:0]           instr_rd;
    logic [RW-1:0]           instr_rs1;
    logic [RW-1:0]           instr_rs2;

    logic                    ld_valid;
    logic                    ld_ready;
    logic [RW-1:0]           ld_addr;
    logic [IN_WIDTH-1:0]     ld_data;

    logic [IN_WIDTH-1:0]     alu_a;
    logic [IN_WIDTH-1:0]     alu_b;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic [2*IN_WIDTH-1:0]   alu_result;

    logic                    done;
    logic [RW-1:0]           dbg_addr;
    logic [IN_WIDTH-1:0]     dbg_data;
    logic [15:0]             instr_count;

    modport slave (
        input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
        output instr_ready,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result,
        output done,
        input  dbg_addr,
        output dbg_data,
        output instr_count
    );

    modport master (
        output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
        input  instr_ready,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result,
        input  done,
        output dbg_addr,
        input  dbg_data,
        input  instr_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Small register-file sequencer for an external combinational ALU. An accepted
// instruction reads its two sources, presents them to the ALU, captures the
// double-width result and writes it back (low half to rd; for multiply, the
// high half also goes to rd+1, wrapping to register 0).
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : alu_sequencer_if.slave (instruction, preload, ALU, debug, counter)
//
// The interface instance must use the same parameter values as this module.
module alu_sequencer #(
    parameter int IN_WIDTH     = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int NUM_REGS     = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(7);
    localparam logic [RW-1:0]           LAST_REG = RW'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB,
        WB_HI
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [IN_WIDTH-1:0]     regs [NUM_REGS];
    logic [IN_WIDTH-1:0]     op_a;
    logic [IN_WIDTH-1:0]     op_b;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [RW-1:0]           rd;
    logic [RW-1:0]           rd_hi;
    logic [2*IN_WIDTH-1:0]   res;
    logic [15:0]             count;

    logic                    instr_ready;
    logic                    ld_ready;
    logic                    done;
    logic                    accept;
    logic                    load;

    assign accept = bus.instr_valid && instr_ready;
    assign load   = bus.ld_valid && ld_ready;

    // The high half of a multiply lands in the register after rd, wrapping
    // explicitly so non-power-of-two register counts still behave.
    assign rd_hi = (rd == LAST_REG) ? '0 : rd + RW'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake/retire outputs. All outputs are gated by rst
    // so nothing is offered or retired while reset is held.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        ld_ready    = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !rst;
                ld_ready    = !rst && !bus.instr_valid;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = WB;
            end
            WB: begin
                if (opcode == OP_MUL) begin
                    state_next = WB_HI;
                end else begin
                    done       = !rst;
                    state_next = IDLE;
                end
            end
            WB_HI: begin
                done       = !rst;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, result capture and retire counter. Sources are read at
    // accept time, so an instruction whose rd aliases a source sees the old
    // value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            opcode <= '0;
            rd     <= '0;
            res    <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                opcode <= bus.instr_opcode;
                rd     <= bus.instr_rd;
                op_a   <= regs[bus.instr_rs1];
                op_b   <= regs[bus.instr_rs2];
            end
            if (state == EXEC) begin
                res <= bus.alu_result;
            end
            if (done) begin
                count <= count + 16'd1;
            end
        end
    end

    // Register file. Preloads only happen in IDLE and writebacks only in
    // WB/WB_HI, so at most one write occurs per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (load) begin
                regs[bus.ld_addr] <= bus.ld_data;
            end else if (state == WB) begin
                regs[rd] <= res[IN_WIDTH-1:0];
            end else if (state == WB_HI) begin
                regs[rd_hi] <= res[2*IN_WIDTH-1:IN_WIDTH];
            end
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.ld_ready    = ld_ready;
    assign bus.done        = done;
    assign bus.alu_a       = op_a;
    assign bus.alu_b       = op_b;
    assign bus.alu_opcode  = opcode;
    assign bus.dbg_data    = regs[bus.dbg_addr];
    assign bus.instr_count = count;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Self-checking bench for alu_sequencer: directed scenarios (add, subtract
// wrap, multiply with rd wrap, instruction/preload priority, undefined opcode
// with operand hold, reset mid-operation) followed by randomized traffic, all
// compared against a register-array reference model.
`timescale 1ns/1ps
module tb_alu_sequencer;
    localparam int W  = 8;
    localparam int OW = 4;
    localparam int NR = 8;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst;

    int errCount   = 0;
    int checkCount = 0;

    logic [W-1:0] mRegs [NR];
    logic [15:0]  mCount;

    alu_sequencer_if #(.IN_WIDTH(W), .OPCODE_WIDTH(OW), .NUM_REGS(NR)) bus ();

    alu_sequencer #(.IN_WIDTH(W), .OPCODE_WIDTH(OW), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    // Behavioural ALU: add, sub, and, or, xor, multiply; anything else is zero.
    function automatic logic [2*W-1:0] aluFunc(input logic [OW-1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a & b);
            4'd3:    return 16'(a | b);
            4'd4:    return 16'(a ^ b);
            4'd7:    return 16'(a) * 16'(b);
            default: return '0;
        endcase
    endfunction

    always_comb bus.alu_result = aluFunc(bus.alu_opcode, bus.alu_a, bus.alu_b);

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Sweeps the debug port over every register (8 x 1ns, fits in half a period).
    task automatic checkRegs(input string tag);
        for (int i = 0; i < NR; i++) begin
            bus.dbg_addr = RW'(i);
            #1;
            checkOutput($sformatf("%s_r%0d", tag, i), 32'(bus.dbg_data), 32'(mRegs[i]));
        end
    endtask

    task automatic applyStimulusLoad(input logic [RW-1:0] addr, input logic [W-1:0] data);
        bus.ld_addr  = addr;
        bus.ld_data  = data;
        bus.ld_valid = 1'b1;
        #1;
        checkOutput("ld_ready", 32'(bus.ld_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        mRegs[addr] = data;
    endtask

    // Issues one instruction and follows it to retirement. When tryLoad is set
    // a preload is held from the handshake cycle through EXEC; it must be
    // dropped in both cycles.
    task automatic applyStimulus(input logic [OW-1:0] op, input logic [RW-1:0] rd,
                                 input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                 input bit tryLoad, input logic [RW-1:0] ldAddr,
                                 input logic [W-1:0] ldData);
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] expRes;
        bit             isMul;
        a      = mRegs[rs1];
        b      = mRegs[rs2];
        expRes = aluFunc(op, a, b);
        isMul  = (op == 4'd7);

        bus.instr_opcode = op;
        bus.instr_rd     = rd;
        bus.instr_rs1    = rs1;
        bus.instr_rs2    = rs2;
        bus.instr_valid  = 1'b1;
        if (tryLoad) begin
            bus.ld_addr  = ldAddr;
            bus.ld_data  = ldData;
            bus.ld_valid = 1'b1;
        end
        #1;
        checkOutput("instr_ready", 32'(bus.instr_ready), 32'd1);
        if (tryLoad) checkOutput("ld_ready_prio", 32'(bus.ld_ready), 32'd0);

        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        checkOutput("alu_a_exec", 32'(bus.alu_a), 32'(a));
        checkOutput("alu_b_exec", 32'(bus.alu_b), 32'(b));
        checkOutput("alu_op_exec", 32'(bus.alu_opcode), 32'(op));
        checkOutput("done_exec", 32'(bus.done), 32'd0);
        checkOutput("instr_ready_exec", 32'(bus.instr_ready), 32'd0);
        if (tryLoad) checkOutput("ld_ready_exec", 32'(bus.ld_ready), 32'd0);

        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        checkOutput("done_wb", 32'(bus.done), isMul ? 32'd0 : 32'd1);
        if (isMul) begin
            @(posedge clk);
            #1;
            checkOutput("done_wbhi", 32'(bus.done), 32'd1);
        end

        mRegs[rd] = expRes[W-1:0];
        if (isMul) mRegs[(int'(rd) + 1) % NR] = expRes[2*W-1:W];
        mCount = mCount + 16'd1;

        @(posedge clk);
        #1;
        checkOutput("done_idle", 32'(bus.done), 32'd0);
        checkOutput("instr_count", 32'(bus.instr_count), 32'(mCount));
        checkOutput("alu_a_hold", 32'(bus.alu_a), 32'(a));
        checkOutput("alu_b_hold", 32'(bus.alu_b), 32'(b));
        checkOutput("alu_op_hold", 32'(bus.alu_opcode), 32'(op));
        checkRegs($sformatf("op%0h", op));
    endtask

    initial begin
        rst              = 1'b1;
        bus.instr_valid  = 1'b1;
        bus.instr_opcode = '0;
        bus.instr_rd     = '0;
        bus.instr_rs1    = '0;
        bus.instr_rs2    = '0;
        bus.ld_valid     = 1'b1;
        bus.ld_addr      = '0;
        bus.ld_data      = 8'h5A;
        bus.dbg_addr     = '0;
        for (int i = 0; i < NR; i++) mRegs[i] = '0;
        mCount = '0;

        // Reset state, with both handshakes offered.
        @(posedge clk);
        #1;
        checkOutput("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
        checkOutput("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("rst_alu_b", 32'(bus.alu_b), 32'd0);
        checkOutput("rst_alu_op", 32'(bus.alu_opcode), 32'd0);
        checkOutput("rst_count", 32'(bus.instr_count), 32'd0);
        checkOutput("rst_dbg", 32'(bus.dbg_data), 32'd0);
        bus.instr_valid = 1'b0;
        bus.ld_valid    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Add.
        applyStimulusLoad(3'd1, 8'h05);
        applyStimulusLoad(3'd2, 8'h03);
        applyStimulus(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
        checkOutput("add_r3", 32'(mRegs[3]), 32'h08);

        // Subtract wrap.
        applyStimulusLoad(3'd1, 8'h03);
        applyStimulusLoad(3'd2, 8'h05);
        applyStimulus(4'b0001, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);

        // Multiply with rd wrap: r7 = 0x00, r0 = 0x02.
        applyStimulusLoad(3'd1, 8'h10);
        applyStimulusLoad(3'd2, 8'h20);
        applyStimulus(4'b0111, 3'd7, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);

        // Priority: preload alongside and during the instruction is dropped.
        applyStimulus(4'b0000, 3'd6, 3'd1, 3'd2, 1'b1, 3'd5, 8'hAA);

        // Undefined opcode writes zero; operand hold checked inside.
        applyStimulus(4'b1111, 3'd2, 3'd1, 3'd3, 1'b0, 3'd0, 8'h00);

        // Randomized traffic, including aliasing and dropped preloads.
        for (int n = 0; n < 30; n++) begin
            int nLoads;
            nLoads = int'($urandom_range(2, 0));
            for (int k = 0; k < nLoads; k++) begin
                applyStimulusLoad(RW'($urandom_range(NR - 1, 0)), W'($urandom));
            end
            applyStimulus(($urandom_range(3, 0) == 0) ? 4'd7 : OW'($urandom_range(15, 0)),
                          RW'($urandom_range(NR - 1, 0)), RW'($urandom_range(NR - 1, 0)),
                          RW'($urandom_range(NR - 1, 0)), 1'($urandom_range(1, 0)),
                          RW'($urandom_range(NR - 1, 0)), W'($urandom));
        end

        // Reset during EXEC of an add to r3: nothing retires.
        applyStimulusLoad(3'd1, 8'h05);
        applyStimulusLoad(3'd2, 8'h03);
        bus.instr_opcode = 4'b0000;
        bus.instr_rd     = 3'd3;
        bus.instr_rs1    = 3'd1;
        bus.instr_rs2    = 3'd2;
        bus.instr_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        bus.dbg_addr = 3'd1;
        #1;
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_instr_ready", 32'(bus.instr_ready), 32'd0);
        checkOutput("midrst_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("midrst_dbg_r1", 32'(bus.dbg_data), 32'd0);
        checkOutput("midrst_count", 32'(bus.instr_count), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checkOutput("midrst_done_hold", 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < NR; i++) mRegs[i] = '0;
        mCount = '0;
        #1;
        checkOutput("postrst_instr_ready", 32'(bus.instr_ready), 32'd1);
        checkOutput("postrst_count", 32'(bus.instr_count), 32'd0);
        checkRegs("postrst");

        // Accept in the first cycle after release.
        applyStimulus(4'b0100, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
